// File: rtl/cpu4_muldiv_ctrl_pkg.sv
// Shared constants and state type for the multi-cycle MUL/DIVU sequencer.
package cpu4_muldiv_ctrl_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_CNT_W = 6;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   localparam logic OP_MUL  = 1'b0;
   localparam logic OP_DIVU = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cpu4_muldiv_ctrl.sv
// Shift-add multiply / restoring divide sequencer that borrows the shared ALU
// one iteration per granted cycle.
module cpu4_muldiv_ctrl
   import cpu4_muldiv_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             kill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] alu_y
);

   state_e           state_q, state_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             alu_req_q, alu_req_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_ctl_q, alu_ctl_d;
   logic             mul_carry;
   logic             div_ok;

   // ALU operands are registered from next-state values so they are valid
   // for the whole RUN cycle that consumes the same-cycle alu_y.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      opb_d     = opb_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      mul_carry = alu_y < alu_a_q;
      div_ok    = hi_q[WIDTH-1] | (alu_y <= alu_a_q);

      case (state_q)
         IDLE: begin
            if (start && !kill) begin
               state_d = RUN;
               op_d    = op;
               opb_d   = src_b;
               hi_d    = '0;
               lo_d    = src_a;
               cnt_d   = CNT_W'(WIDTH);
            end
         end
         RUN: begin
            if (kill) begin
               state_d = IDLE;
            end else if (alu_gnt) begin
               if (op_q == OP_DIVU) begin
                  hi_d = div_ok ? alu_y : alu_a_q;
                  lo_d = {lo_q[WIDTH-2:0], div_ok};
               end else begin
                  hi_d = {mul_carry, alu_y[WIDTH-1:1]};
                  lo_d = {alu_y[0], lo_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
      alu_req_d = (state_d == RUN);
      alu_a_d   = '0;
      alu_b_d   = '0;
      alu_ctl_d = 3'b000;
      if (state_d == RUN) begin
         if (op_d == OP_MUL) begin
            alu_a_d   = hi_d;
            alu_b_d   = lo_d[0] ? opb_d : '0;
            alu_ctl_d = ALU_ADD;
         end else begin
            alu_a_d   = {hi_d[WIDTH-2:0], lo_d[WIDTH-1]};
            alu_b_d   = opb_d;
            alu_ctl_d = ALU_SUB;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= OP_MUL;
         opb_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         alu_req_q <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_ctl_q <= 3'b000;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         opb_q     <= opb_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         alu_req_q <= alu_req_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_ctl_q <= alu_ctl_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign result_hi   = hi_q;
   assign result_lo   = lo_q;
   assign alu_req     = alu_req_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_control = alu_ctl_q;

endmodule

// File: tb/tb_cpu4_muldiv_ctrl.sv
// Bench for cpu4_muldiv_ctrl: arithmetic reference model plus per-cycle compare.
module tb_cpu4_muldiv_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        kill;
   logic        busy;
   logic        done;
   logic [31:0] result_hi;
   logic [31:0] result_lo;
   logic        alu_req;
   logic        alu_gnt;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_control;
   logic [31:0] alu_y;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int gmode  = 0;   // 0: grant tied high, 1: alternate starting granted, 2: random
   int g_t0   = 0;

   // reference model state
   int          m_mode   = 0;  // 0 idle, 1 running, 2 done
   int          m_grants = 0;
   logic        m_op     = 1'b0;
   logic [31:0] m_a      = '0;
   logic [31:0] m_b      = '0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;
   logic        m_valid  = 1'b0;

   logic        p_req = 1'b0;
   logic        p_gnt = 1'b0;
   logic [31:0] p_a   = '0;
   logic [31:0] p_b   = '0;

   cpu4_muldiv_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .kill(kill),
      .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
      .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
      .alu_control(alu_control), .alu_y(alu_y)
   );

   assign alu_y = (alu_control == 3'b010) ? alu_a + alu_b :
                  (alu_control == 3'b110) ? alu_a - alu_b : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input logic o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      if (!o) begin
         p = 64'(a) * 64'(b);
      end else if (b == 32'h0) begin
         p = {a, 32'hFFFF_FFFF};
      end else begin
         p = {a % b, a / b};
      end
      return p;
   endfunction

   // grant driver
   always @(posedge clk) begin
      #1;
      case (gmode)
         0:       alu_gnt = 1'b1;
         1:       alu_gnt = ((cyc - g_t0) % 2) == 0;
         default: alu_gnt = ($urandom_range(0, 3) != 0);
      endcase
   end

   // reference model: advances on each edge from the sampled inputs
   always @(posedge clk) begin
      logic [63:0] r;
      if (reset) begin
         m_mode = 0; m_hi = '0; m_lo = '0; m_valid = 1'b1;
      end else begin
         case (m_mode)
            0: if (start && !kill) begin
                  m_mode = 1; m_grants = 0; m_op = op; m_a = src_a; m_b = src_b; m_valid = 1'b0;
               end
            1: if (kill) begin
                  m_mode = 0;
               end else if (alu_gnt) begin
                  m_grants++;
                  if (m_grants == 32) begin
                     r = ref_res(m_op, m_a, m_b);
                     m_hi = r[63:32]; m_lo = r[31:0]; m_valid = 1'b1; m_mode = 2;
                  end
               end
            default: m_mode = 0;
         endcase
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("busy", 64'(busy), 64'(m_mode != 0));
         chk("done", 64'(done), 64'(m_mode == 2));
         chk("alu_req", 64'(alu_req), 64'(m_mode == 1));
         if (m_valid) begin
            chk("result_hi", 64'(result_hi), 64'(m_hi));
            chk("result_lo", 64'(result_lo), 64'(m_lo));
         end
         if (m_mode == 1) begin
            if (!m_op) begin
               chk("alu_ctl_add", 64'(alu_control), 64'(3'b010));
               chk("mul_alu_b", 64'(alu_b == 32'h0 || alu_b == m_b), 64'(1));
            end else begin
               chk("alu_ctl_sub", 64'(alu_control), 64'(3'b110));
               chk("div_alu_b", 64'(alu_b), 64'(m_b));
            end
            if (p_req && !p_gnt) begin
               chk("hold_alu_a", 64'(alu_a), 64'(p_a));
               chk("hold_alu_b", 64'(alu_b), 64'(p_b));
            end
         end else begin
            chk("alu_idle", {alu_a, alu_b | 32'(alu_control)}, 64'h0);
         end
      end
      p_req = alu_req; p_gnt = alu_gnt; p_a = alu_a; p_b = alu_b;
   end

   // called at posedge+1; returns with start sampled and cycle = first RUN cycle
   task automatic do_start(input logic o, input logic [31:0] a, input logic [31:0] b,
                           output int t_start);
      g_t0 = cyc + 1;
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      t_start = cyc;
   endtask

   // returns at the negedge of the done cycle (or after timeout)
   task automatic wait_done(output int t_done);
      int n;
      n = 0;
      while (n < 300 && !done) begin
         @(negedge clk);
         if (!done) n++;
      end
      chk("done_seen", 64'(n < 300), 64'(1));
      t_done = cyc;
   endtask

   task automatic realign();
      @(posedge clk); #1;
   endtask

   task automatic run_check(input logic o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input string name);
      int ts, td;
      do_start(o, a, b, ts);
      wait_done(td);
      chk({name, "_hi"}, 64'(result_hi), 64'(ehi));
      chk({name, "_lo"}, 64'(result_lo), 64'(elo));
      realign();
   endtask

   initial begin
      int ts, td, nd;
      logic [31:0] ra, rb;
      logic        ro;
      reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0; kill = 1'b0; alu_gnt = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_outputs", {30'h0, busy, done, result_hi}, 64'h0);
      chk("rst_lo_req", {31'h0, alu_req, result_lo}, 64'h0);

      // MUL 7*6 with latency check; start during DONE must be ignored
      gmode = 0;
      do_start(1'b0, 32'd7, 32'd6, ts);
      chk("busy_first", 64'(busy), 64'(1));
      wait_done(td);
      chk("lat_tied", 64'(td - ts), 64'(32));
      chk("mul7x6", {result_hi, result_lo}, 64'd42);
      start = 1'b1; op = 1'b1; src_a = 32'd9; src_b = 32'd3;
      realign();
      start = 1'b0;
      chk("start_in_done", 64'(busy), 64'(0));
      realign();

      run_check(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, "mul_max");

      // DIVU 100/7 with a stray start while busy
      do_start(1'b1, 32'd100, 32'd7, ts);
      repeat (3) realign();
      start = 1'b1; op = 1'b0; src_a = 32'd5; src_b = 32'd5;
      realign();
      start = 1'b0;
      wait_done(td);
      chk("div100_7", {result_hi, result_lo}, {32'd2, 32'd14});
      realign();

      run_check(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, "div_top");
      run_check(1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, "div_zero");

      // alternating grant
      gmode = 1;
      do_start(1'b0, 32'h1_0000, 32'h1_0000, ts);
      wait_done(td);
      chk("lat_alt", 64'(td - ts), 64'(63));
      chk("mul_alt", {result_hi, result_lo}, {32'h1, 32'h0});
      realign();
      gmode = 0;

      // kill at iteration 10
      do_start(1'b0, 32'd11, 32'd13, ts);
      repeat (10) realign();
      kill = 1'b1;
      realign();
      kill = 1'b0;
      chk("kill_idle", {31'h0, busy, 31'h0, alu_req}, 64'h0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("kill_no_done", 64'(nd), 64'(0));
      realign();

      // reset at iteration 5, then a fresh MUL
      do_start(1'b0, 32'd123, 32'd456, ts);
      repeat (5) realign();
      reset = 1'b1;
      realign();
      reset = 1'b0;
      chk("midrst_a", {30'h0, busy, done, result_hi}, 64'h0);
      chk("midrst_b", {31'h0, alu_req, result_lo}, 64'h0);
      chk("midrst_alu", {alu_a, alu_b | 32'(alu_control)}, 64'h0);
      run_check(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, "mul3x5");

      // randomized operations with random grants and occasional kills
      gmode = 2;
      for (int i = 0; i < 40; i++) begin
         ro = 1'($urandom_range(0, 1));
         ra = $urandom();
         case ($urandom_range(0, 3))
            0:       rb = 32'h0;
            1:       rb = 32'($urandom_range(1, 255));
            default: rb = $urandom();
         endcase
         do_start(ro, ra, rb, ts);
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 30)) realign();
            kill = 1'b1;
            realign();
            kill = 1'b0;
         end else begin
            wait_done(td);
            realign();
         end
         repeat ($urandom_range(0, 2)) realign();
      end

      realign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
